// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the requester handshake and the transmitter control signals of the
// shared UART TX arbiter.
//
// Parameters:
//   NUM_REQ   number of requesters
//   ID_W      width of the grant index, clog2(NUM_REQ)
//
// Signals:
//   req_valid  [NUM_REQ]    per-requester byte available, held until accepted
//   req_data   [8*NUM_REQ]  requester i's byte on bits [8i+7:8i]
//   req_ready  [NUM_REQ]    one-hot, one-cycle accept pulse
//   tx_busy                 transmitter is shifting a frame
//   tx_done                 one-cycle pulse at the end of a stop bit
//   tx_start                one-cycle pulse, transmitter loads tx_data
//   tx_data    [8]          byte presented to the transmitter
//   grant_id   [ID_W]       current or last granted requester
//   active                  arbiter is not idle
//
// Modports:
//   master  the arbiter side
//   slave   the requester/transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [ID_W-1:0]      grant_id;
    logic                 active;

    modport master (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, active
    );

    modport slave (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. A winner is picked in IDLE starting at the round-robin pointer,
// its byte is accepted with a one-cycle req_ready pulse, handed to the
// transmitter with a one-cycle tx_start pulse, and the arbiter waits for
// tx_done before arbitrating again.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   uart_tx_arbiter_if.master (handshake and transmitter signals)
//
// Configuration macro:
//   UART_ARB_TAG_EN  when defined, every granted byte is preceded by a tag
//                    frame 8'hA0 | grant_id (two tx_start pulses per grant).
//
// All outputs are registered; tx_start is raised on the edge that enters a
// SEND state when the transmitter is already free, so the pulse coincides
// with the first SEND cycle.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam logic [ID_W:0]        NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);
    localparam logic [7:0]           TAG_BASE  = 8'hA0;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
`ifdef UART_ARB_TAG_EN
        SEND_TAG,
        WAIT_TAG,
`endif
        SEND_DATA,
        WAIT_DATA
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_q;
    logic [7:0]      data_q;

    logic            rr_found;
    logic [ID_W-1:0] rr_win;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   win_inc;
    logic [ID_W-1:0] ptr_next;
    logic [7:0]      win_byte;

    // Round-robin search: first valid requester at ptr, ptr+1, ... (mod NUM_REQ).
    // The extra bit on cand keeps the wrap correct for non-power-of-two counts,
    // so indices >= NUM_REQ are never produced.
    // NOTE: every variable gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!rr_found && bus.req_valid[cand[ID_W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = cand[ID_W-1:0];
            end
        end
    end

    assign win_inc  = {1'b0, win_q} + (ID_W+1)'(1);
    assign ptr_next = (win_inc == NUM_REQ_W) ? '0 : win_inc[ID_W-1:0];
    assign win_byte = bus.req_data[{win_q, 3'b000} +: 8];

    // NOTE: state and outputs are sequential, so they use non-blocking
    // assignments; reads of bus.tx_start below see the value from the
    // previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            win_q         <= '0;
            data_q        <= 8'h00;
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.grant_id  <= '0;
            bus.active    <= 1'b0;
        end else begin
            // Both pulses last exactly one cycle unless re-raised below.
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rr_found) begin
                        win_q         <= rr_win;
                        bus.req_ready <= ONE_HOT0 << rr_win;
                        bus.active    <= 1'b1;
                        state         <= GRANT;
                    end
                end

                GRANT: begin
                    // The requester holds its byte through the ready cycle,
                    // so it is captured here; later valid drops are harmless.
                    data_q       <= win_byte;
                    bus.grant_id <= win_q;
                    ptr          <= ptr_next;
`ifdef UART_ARB_TAG_EN
                    state <= SEND_TAG;
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= TAG_BASE | 8'(win_q);
                    end
`else
                    state <= SEND_DATA;
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= win_byte;
                    end
`endif
                end

`ifdef UART_ARB_TAG_EN
                SEND_TAG: begin
                    if (bus.tx_start) begin
                        state <= WAIT_TAG;
                    end else if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= TAG_BASE | 8'(win_q);
                    end
                end

                WAIT_TAG: begin
                    if (bus.tx_done) begin
                        state <= SEND_DATA;
                        if (!bus.tx_busy) begin
                            bus.tx_start <= 1'b1;
                            bus.tx_data  <= data_q;
                        end
                    end
                end
`endif

                SEND_DATA: begin
                    if (bus.tx_start) begin
                        state <= WAIT_DATA;
                    end else if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= data_q;
                    end
                end

                WAIT_DATA: begin
                    if (bus.tx_done) begin
                        state      <= IDLE;
                        bus.active <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Expected transmitter bytes are queued
// when a request is driven and popped when tx_start appears; a small
// transmitter model raises tx_busy and a tx_done pulse FRAME cycles after
// each tx_start. Honors UART_ARB_TAG_EN by expecting a tag frame per grant.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int FRAME   = 10;
`ifdef UART_ARB_TAG_EN
    localparam int FRAMES_PER = 2;
`else
    localparam int FRAMES_PER = 1;
`endif

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         grant_log[$];
    logic [7:0] last_exp = 8'h00;

    // Transmitter model and manual overrides.
    logic auto_tx  = 1'b1;
    logic busy_man = 1'b0;
    logic done_man = 1'b0;
    logic busy_m   = 1'b0;
    logic done_m   = 1'b0;
    int   timer    = 0;

    assign bus.tx_busy = auto_tx ? busy_m : busy_man;
    assign bus.tx_done = done_m | done_man;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int id, input logic [7:0] d);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'hA0 | 8'(id));
`endif
        exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && bus.active; i++) tick();
        check(tag, 32'(bus.active), 0);
    endtask

    task automatic wait_grants(input string tag, input int n);
        for (int i = 0; i < 400 && grant_log.size() < n; i++) tick();
        check(tag, grant_log.size(), n);
    endtask

    // Follows the frames of one grant; active must stay high until the last
    // tx_done and be low on the edge that consumed it.
    task automatic wait_frames_idle(input string tag);
        int   dones       = 0;
        logic prev_active = 1'b1;
        for (int i = 0; i < 400 && dones < FRAMES_PER; i++) begin
            tick();
            if (bus.tx_done) begin
                dones++;
                if (dones < FRAMES_PER) begin
                    check({tag, "_active_mid"}, 32'(bus.active), 1);
                end else begin
                    check({tag, "_active_drop"}, 32'(bus.active), 0);
                    check({tag, "_active_before"}, 32'(prev_active), 1);
                end
            end
            prev_active = bus.active;
        end
        check({tag, "_frames"}, dones, FRAMES_PER);
    endtask

    // Monitor, scoreboard and transmitter model share one process so the
    // model's busy flag is read before it is updated.
    always @(negedge clk) begin
        if (rst) begin
            busy_m = 1'b0;
            done_m = 1'b0;
            timer  = 0;
        end else begin
            if (bus.req_ready != '0) begin
                check("ready_onehot", $countones(bus.req_ready), 1);
                check("ready_to_valid", 32'(|(bus.req_ready & bus.req_valid)), 1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus.req_ready[i]) grant_log.push_back(i);
                end
            end
            if (bus.tx_start) begin
                check("start_while_busy", 32'(bus.tx_busy), 0);
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", exp_q.size(), 1);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("tx_data", bus.tx_data, last_exp);
                end
                busy_m = 1'b1;
                timer  = FRAME;
            end else if (done_m) begin
                done_m = 1'b0;
                busy_m = 1'b0;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) done_m = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2_order[5];
        t2_order = '{0, 1, 2, 3, 0};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        tick();
        tick();

        // Reset values.
        check("rst_ready",    bus.req_ready, 0);
        check("rst_start",    32'(bus.tx_start), 0);
        check("rst_data",     bus.tx_data, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_active",   32'(bus.active), 0);
        rst = 1'b0;

        // Single request from requester 1.
        bus.req_valid        = 4'b0010;
        bus.req_data[15:8]   = 8'h5A;
        expect_frame(1, 8'h5A);
        tick();
        check("t1_ready",    bus.req_ready, 4'b0010);
        check("t1_active",   32'(bus.active), 1);
        check("t1_no_start", 32'(bus.tx_start), 0);
        tick();
        check("t1_ready_pulse", bus.req_ready, 0);
        check("t1_start",       32'(bus.tx_start), 1);
        check("t1_grant_id",    bus.grant_id, 1);
        bus.req_valid = '0;
        wait_frames_idle("t1");

        // Round-robin fairness from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) expect_frame(t2_order[i], 8'h10 + 8'(t2_order[i]));
        wait_grants("t2_grants", 5);
        bus.req_valid = '0;
        wait_idle("t2_idle");
        for (int i = 0; i < 5; i++) check("t2_order", grant_log[i], t2_order[i]);

        // Busy hold: transmitter busy while the arbiter sits in SEND.
        auto_tx              = 1'b0;
        busy_man             = 1'b1;
        bus.req_data[31:24]  = 8'h3C;
        bus.req_valid        = 4'b1000;
        expect_frame(3, 8'h3C);
        tick();
        check("t3_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_start", 32'(bus.tx_start), 0);
            check("t3_hold_data",  bus.tx_data, last_exp);
            tick();
        end
        busy_man = 1'b0;
        auto_tx  = 1'b1;
        tick();
        check("t3_start", 32'(bus.tx_start), 1);
        wait_frames_idle("t3");

        // Requester 3 with 8'hC3 (tag 8'hA3 first when tagging).
        bus.req_data[31:24] = 8'hC3;
        bus.req_valid       = 4'b1000;
        expect_frame(3, 8'hC3);
        tick();
        check("t4_ready", bus.req_ready, 4'b1000);
        tick();
        check("t4_start",    32'(bus.tx_start), 1);
        check("t4_grant_id", bus.grant_id, 3);
        bus.req_valid = '0;
        wait_frames_idle("t4");

        // Reset during WAIT_DATA.
        bus.req_data[15:8] = 8'h77;
        bus.req_valid      = 4'b0010;
        expect_frame(1, 8'h77);
        tick();
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        check("t5_sent", exp_q.size(), 0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_ready",    bus.req_ready, 0);
        check("t5_rst_start",    32'(bus.tx_start), 0);
        check("t5_rst_data",     bus.tx_data, 0);
        check("t5_rst_grant_id", bus.grant_id, 0);
        check("t5_rst_active",   32'(bus.active), 0);
        rst = 1'b0;
        tick();
        check("t5_post_start",  32'(bus.tx_start), 0);
        check("t5_post_active", 32'(bus.active), 0);
        grant_log.delete();
        bus.req_data[7:0]   = 8'hA5;
        bus.req_data[23:16] = 8'h5B;
        bus.req_valid       = 4'b0101;
        expect_frame(0, 8'hA5);
        expect_frame(2, 8'h5B);
        wait_grants("t5_grant0", 1);
        bus.req_valid[0] = 1'b0;
        wait_grants("t5_grant1", 2);
        bus.req_valid = '0;
        wait_idle("t5_idle");
        check("t5_first",  grant_log[0], 0);
        check("t5_second", grant_log[1], 2);

        // Spurious tx_done in IDLE and GRANT.
        tick();
        done_man = 1'b1;
        tick();
        check("t6_idle_active", 32'(bus.active), 0);
        check("t6_idle_start",  32'(bus.tx_start), 0);
        check("t6_idle_ready",  bus.req_ready, 0);
        bus.req_data[15:8] = 8'hE1;
        bus.req_valid      = 4'b0010;
        expect_frame(1, 8'hE1);
        tick();
        check("t6_ready", bus.req_ready, 4'b0010);
        tick();
        done_man = 1'b0;
        check("t6_start",    32'(bus.tx_start), 1);
        check("t6_grant_id", bus.grant_id, 1);
        bus.req_valid = '0;
        wait_frames_idle("t6");

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
